// File: rtl/ysyx_24100027_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100027_pkg
// Brief    : Shared constants and FSM encoding for the NPC PC stage.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_24100027_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_FETCH     = 3'd1;
    localparam state_t ST_WAIT_RESP = 3'd2;
    localparam state_t ST_EXEC      = 3'd3;
    localparam state_t ST_HALT      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100027_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100027_pc_unit_if
// Brief    : Fetch request/response handshake between PC stage and IFU.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_24100027_pc_unit_if;

    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_resp_valid
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_resp_valid
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_24100027_dnpc_calc.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100027_dnpc_calc
// Brief    : Combinational next-PC adder, shared with the difftest model.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100027_dnpc_calc
    import ysyx_24100027_pkg::*;
(
    input  wire logic        PCActr,
    input  wire logic        PCBctr,
    input  wire logic [31:0] imm,
    input  wire logic [31:0] rs1,
    input  wire logic [31:0] pc,
    output logic      [31:0] dnpc
);

    logic [31:0] w_opa;
    logic [31:0] w_opb;
    logic [31:0] w_sum;

    assign w_opa = PCActr ? imm : PC_STEP;
    assign w_opb = PCBctr ? rs1 : pc;
    assign w_sum = w_opa + w_opb;

    // Register-based targets (jalr) drop bit 0; pc-relative sums are left intact.
    assign dnpc = PCBctr ? {w_sum[31:1], 1'b0} : w_sum;

endmodule
`default_nettype wire

// File: rtl/ysyx_24100027_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100027_pc_unit
// Brief    : PC stage: fetch/exec sequencing, next-PC commit, trap redirect,
//            misaligned-target halt and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100027_pc_unit
    import ysyx_24100027_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        PCActr,
    input  wire logic        PCBctr,
    input  wire logic [31:0] imm,
    input  wire logic [31:0] rs1,
    input  wire logic        commit,
    input  wire logic        trap_valid,
    input  wire logic [31:0] trap_target,
    ysyx_24100027_pc_unit_if.master ifu,
    output logic      [31:0] pc,
    output logic      [31:0] dnpc,
    output logic      [63:0] instret,
    output logic             misalign
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [63:0] r_instret;
    logic        r_misalign;

    logic [31:0] w_dnpc;
    logic [31:0] w_target;
    logic        w_commit;
    logic        w_target_misaligned;

    ysyx_24100027_dnpc_calc u_dnpc_calc (
        .PCActr (PCActr),
        .PCBctr (PCBctr),
        .imm    (imm),
        .rs1    (rs1),
        .pc     (r_pc),
        .dnpc   (w_dnpc)
    );

    assign w_commit            = (r_state == ST_EXEC) && commit;
    assign w_target            = trap_valid ? trap_target : w_dnpc;
    assign w_target_misaligned = |w_target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instret  <= 64'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (ifu.ifu_req_ready) r_state <= ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    if (ifu.ifu_resp_valid) r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_commit) begin
                        // Misaligned commits still retire; the PC is frozen on the
                        // offending instruction so the halt point is observable.
                        r_instret <= r_instret + 64'd1;
                        if (w_target_misaligned) begin
                            r_misalign <= 1'b1;
                            r_state    <= ST_HALT;
                        end else begin
                            r_pc    <= w_target;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ifu.ifu_req_valid = (r_state == ST_FETCH);
    assign ifu.ifu_req_addr  = r_pc;

    assign pc       = r_pc;
    assign dnpc     = w_dnpc;
    assign instret  = r_instret;
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100027_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100027_pc_unit
// Brief    : Scoreboard bench: expected {instret, fetch addr} queued per
//            instruction, popped on every accepted fetch request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100027_pc_unit;

    logic        clk;
    logic        rst;
    logic        PCActr;
    logic        PCBctr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        commit;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [63:0] instret;
    logic        misalign;

    ysyx_24100027_pc_unit_if ifu_bus ();

    ysyx_24100027_pc_unit #(.RESET_PC(32'h8000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCActr      (PCActr),
        .PCBctr      (PCBctr),
        .imm         (imm),
        .rs1         (rs1),
        .commit      (commit),
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .ifu         (ifu_bus),
        .pc          (pc),
        .dnpc        (dnpc),
        .instret     (instret),
        .misalign    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_fetch = 0;
    logic [95:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch request is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && ifu_bus.ifu_req_valid === 1'b1 && ifu_bus.ifu_req_ready === 1'b1) begin
            n_fetch++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_fetch: got addr %h with empty queue", ifu_bus.ifu_req_addr);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                chk("fetch_addr", {32'd0, ifu_bus.ifu_req_addr}, {32'd0, e[31:0]});
                chk("fetch_instret", instret, e[95:32]);
            end
        end
    end

    task automatic wait_fetch(output int cyc);
        int start;
        start = n_fetch;
        cyc   = 0;
        while (n_fetch == start && cyc < 40) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (n_fetch == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: got no fetch after %0d cycles, expected one", cyc);
        end
    endtask

    task automatic instr(input logic a, input logic b, input logic [31:0] i,
                         input logic [31:0] r, input logic t, input logic [31:0] tt,
                         input logic [31:0] exp_pc, input logic [63:0] exp_ret,
                         output int cyc);
        PCActr      = a;
        PCBctr      = b;
        imm         = i;
        rs1         = r;
        trap_valid  = t;
        trap_target = tt;
        exp_q.push_back({exp_ret, exp_pc});
        wait_fetch(cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; PCActr = 1'b0; PCBctr = 1'b0; imm = 32'd0; rs1 = 32'd0;
        commit = 1'b1; trap_valid = 1'b0; trap_target = 32'd0;
        ifu_bus.ifu_req_ready  = 1'b1;
        ifu_bus.ifu_resp_valid = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", {32'd0, pc}, 64'h8000_0000);
        chk("reset_instret", instret, 64'd0);
        chk("reset_misalign", {63'd0, misalign}, 64'd0);
        chk("reset_req_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd0);

        @(posedge clk); #2;
        exp_q.push_back({64'd0, 32'h8000_0000});
        rst = 1'b0;
        wait_fetch(cyc);
        chk("first_fetch_latency", cyc, 2);

        // Sequential stream with ready/resp tied high: one instruction per 3 cycles.
        for (int k = 1; k <= 4; k++) begin
            instr(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h8000_0000 + 32'(4 * k), 64'(k), cyc);
            chk("seq_period", cyc, 3);
        end

        instr(1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, 1'b0, 32'd0, 32'h8000_0008, 64'd5, cyc);
        instr(1'b1, 1'b1, 32'd3, 32'h8000_0101, 1'b0, 32'd0, 32'h8000_0104, 64'd6, cyc);
        instr(1'b0, 1'b1, 32'd0, 32'h8000_0201, 1'b0, 32'd0, 32'h8000_0204, 64'd7, cyc);

        // Backpressure: stall the request, with a live commit that must be ignored.
        PCActr = 1'b0; PCBctr = 1'b0;
        ifu_bus.ifu_req_ready = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        PCActr = 1'b1; imm = 32'h100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd1);
            chk("stall_addr", {32'd0, ifu_bus.ifu_req_addr}, 64'h8000_0208);
            chk("stall_instret", instret, 64'd8);
        end
        chk("stall_pc", {32'd0, pc}, 64'h8000_0208);
        @(posedge clk); #2;
        exp_q.push_back({64'd8, 32'h8000_0208});
        ifu_bus.ifu_req_ready = 1'b1;
        wait_fetch(cyc);

        instr(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 32'h8000_0200, 32'h8000_0200, 64'd9, cyc);

        // Counter wrap: preload all-ones while waiting for the response.
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        instr(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h8000_0204, 64'd0, cyc);

        instr(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'd1, cyc);

        // Misaligned pc+imm target halts with pc frozen.
        PCActr = 1'b1; PCBctr = 1'b0; imm = 32'd2; trap_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("halt_dnpc", {32'd0, dnpc}, 64'h8000_0002);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
            chk("halt_misalign", {63'd0, misalign}, 64'd1);
            chk("halt_pc", {32'd0, pc}, 64'h8000_0000);
            chk("halt_instret", instret, 64'd2);
        end

        @(posedge clk); #2;
        rst = 1'b1; PCActr = 1'b0; imm = 32'd0;
        @(posedge clk); #2;
        @(negedge clk);
        chk("rehalt_pc", {32'd0, pc}, 64'h8000_0000);
        chk("rehalt_misalign", {63'd0, misalign}, 64'd0);
        chk("rehalt_instret", instret, 64'd0);
        @(posedge clk); #2;
        exp_q.push_back({64'd0, 32'h8000_0000});
        rst = 1'b0;
        wait_fetch(cyc);
        chk("refetch_latency", cyc, 2);

        // Reset while waiting for a response; the late response must be ignored.
        instr(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h8000_0004, 64'd1, cyc);
        ifu_bus.ifu_resp_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        ifu_bus.ifu_resp_valid = 1'b1;
        exp_q.push_back({64'd0, 32'h8000_0000});
        @(negedge clk);
        chk("midrst_pc", {32'd0, pc}, 64'h8000_0000);
        chk("midrst_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
        chk("midrst_instret", instret, 64'd0);
        wait_fetch(cyc);
        ifu_bus.ifu_req_ready = 1'b0;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24100027_pc_unit.md
# ysyx_24100027_pc_unit

Program-counter stage of the multi-cycle NPC core, directly downstream of the branch controller. Each instruction is sequenced through fetch request, instruction response and execute. At commit, the unit consumes the branch controller's PCActr/PCBctr selects, computes the dynamic next PC (dnpc) and updates the architectural PC. The unit also applies trap redirects, halts on a misaligned target and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- PCActr  in  1  adder operand A select from branch controller: 1 = imm, 0 = constant 4.
- PCBctr  in  1  adder operand B select from branch controller: 1 = rs1, 0 = pc.
- imm  in  32  sign-extended immediate of the current instruction.
- rs1  in  32  rs1 register value of the current instruction.
- commit  in  1  EXU pulse: current instruction done; select/operand inputs are valid this cycle.
- trap_valid  in  1  qualifies commit; redirect to trap_target (ecall/mret).
- trap_target  in  32  redirect address (mtvec/mepc).
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  IFU accepts the request.
- ifu_req_addr  out  32  fetch address; always equals pc.
- ifu_resp_valid  in  1  instruction returned.
- pc  out  32  architectural PC.
- dnpc  out  32  combinational next-PC candidate, for difftest.
- instret  out  64  retired-instruction counter.
- misalign  out  1  sticky; set when halted on a misaligned target.

## Operation
- States: IDLE, FETCH, WAIT_RESP, EXEC, HALT.
- IDLE → FETCH unconditionally.
- FETCH: ifu_req_valid=1. On ifu_req_ready → WAIT_RESP.
- WAIT_RESP: on ifu_resp_valid → EXEC.
- EXEC: waits for commit.
- On commit in EXEC:
  - target = trap_valid ? trap_target : dnpc.
  - If target[1:0] != 0 (no C extension): pc unchanged, misalign←1, → HALT.
  - Otherwise: pc←target, → FETCH.
- instret increments by 1 on every commit taken in EXEC, including trap and misaligned commits. It wraps 2^64−1 → 0.
- dnpc arithmetic: sum = (PCActr ? imm : 32'd4) + (PCBctr ? rs1 : pc), modulo 2^32; dnpc = PCBctr ? {sum[31:1],1'b0} : sum. Select meanings:
  - 0/0: sequential (pc+4).
  - 1/0: jal or taken branch (pc+imm).
  - 1/1: jalr (rs1+imm, bit 0 cleared).
  - 0/1: rs1+4; defined but unused.
- HALT: absorbing. ifu_req_valid=0; commit and ifu_resp_valid are ignored. Only rst exits HALT.
- Inputs ignored outside their state: commit outside EXEC, ifu_resp_valid outside WAIT_RESP, ifu_req_ready outside FETCH.

## Timing
- Reset values (rst high at an edge): state=IDLE, pc=RESET_PC, instret=0, misalign=0, ifu_req_valid=0.
- First request: ifu_req_valid rises 2 cycles after the last rst-high edge (IDLE takes one cycle).
- Request hold: ifu_req_valid/ifu_req_addr stay stable while valid && !ready. Valid never deasserts before acceptance.
- Minimum instruction period is 3 cycles: FETCH with ready=1 → WAIT_RESP with resp=1 → EXEC with commit=1.
- pc and instret update on the edge that samples commit. The new fetch request is visible the following cycle.
- Simultaneous trap_valid and commit: trap target wins over dnpc. trap_valid without commit has no effect.
- Reset mid-operation: rst in any state, including mid-handshake, aborts to IDLE at that edge. The request is dropped with no completion.

## Structure
- ysyx_24100027_pkg holds:
  - state enum (IDLE, FETCH, WAIT_RESP, EXEC, HALT);
  - PC_STEP = 32'd4;
  - RESET_PC default constant.
- One combinational sub-module, ysyx_24100027_dnpc_calc: inputs PCActr, PCBctr, imm, rs1, pc; output dnpc. It is reusable by the difftest reference model.
- FSM, PC register and instret counter live in the top module.

## Test plan
- Sequential fetch: reset, ready and resp tied 1, commit each EXEC with PCActr=0, PCBctr=0 → pc = 8000_0000, 8000_0004, 8000_0008; one instruction per 3 cycles; instret=3.
- Branch and jalr: pc=8000_0010, PCActr=1, PCBctr=0, imm=FFFF_FFF8 → pc=8000_0008. Then PCActr=1, PCBctr=1, rs1=8000_0101, imm=3 → pc=8000_0104 (bit 0 cleared).
- Backpressure: ifu_req_ready low 5 cycles → ifu_req_valid=1 and ifu_req_addr stable throughout; a commit pulsed during FETCH is ignored (pc and instret unchanged).
- Trap priority: commit with trap_valid=1, trap_target=8000_0200, PCActr=1, imm=0x40 → pc=8000_0200, instret+1.
- Misalign: pc=8000_0000, PCActr=1, imm=2 → misalign=1, pc stays 8000_0000, ifu_req_valid=0 indefinitely. A subsequent rst restores pc=8000_0000, misalign=0.
- Wrap and reset mid-handshake: force instret to 2^64−1, commit → instret=0. Assert rst in WAIT_RESP → state IDLE and pc=RESET_PC next cycle; a late ifu_resp_valid is ignored.
